// File: rtl/mrd_source_stream.sv
// Source streamer: reads dftpts result samples in address order, emits a sop/eop framed stream.
// Latency: first beat valid 3 cycles after start, then one beat per cycle while ready is held.
// Backpressure: reads are credited against a 2-entry buffer; at most one read issues after ready drops.
module mrd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [W-1:0]                 rd_dat,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);
    // Generic FIFO: push/pop in the same cycle allowed, head visible combinationally.
    // Latency: 1 cycle from push to head. Backpressure: push into a full FIFO without pop is dropped.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module mrd_source_stream #(
    parameter int DW = 18,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [11:0]   dftpts,
    input  logic          inverse,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_real,
    input  logic [DW-1:0] rd_imag,
    output logic          source_valid,
    input  logic          source_ready,
    output logic          source_sop,
    output logic          source_eop,
    output logic [DW-1:0] source_real,
    output logic [DW-1:0] source_imag,
    output logic [11:0]   source_dftpts,
    output logic          source_inverse,
    output logic          source_ongoing,
    output logic          done
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } beat_t;

    state_t        state;
    state_t        state_nxt;
    logic [11:0]   dftpts_q;
    logic          inverse_q;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] rd_addr_q;
    logic [AW-1:0] last_addr;
    logic          rd_vld_q;
    logic          start_acc;
    logic          pop;
    logic          fifo_push;
    logic          fifo_empty;
    logic [1:0]    fifo_cnt;
    logic [2:0]    occ;
    beat_t         push_dat;
    beat_t         head;

    assign last_addr = AW'(dftpts_q - 12'd1);
    assign pop       = source_valid & source_ready;
    // Buffered plus in-flight beats; a read may issue only if its data is sure to find a free slot.
    assign occ       = {1'b0, fifo_cnt} + {2'b00, rd_vld_q};

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        start_acc = 1'b0;
        case (state)
            IDLE: begin
                if (start && (dftpts != 12'd0)) begin
                    start_acc = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                rd_en = (occ < (3'd2 + {2'b00, pop}));
                if (rd_en && (rd_cnt == last_addr)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head.eop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dftpts_q  <= '0;
            inverse_q <= 1'b0;
            rd_cnt    <= '0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            done      <= 1'b0;
        end else begin
            if (start_acc) begin
                dftpts_q  <= dftpts;
                inverse_q <= inverse;
                rd_cnt    <= '0;
            end else if (rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            rd_vld_q  <= rd_en;
            rd_addr_q <= rd_cnt;
            done      <= pop & head.eop;
        end
    end

    assign fifo_push = rd_vld_q;
    assign push_dat  = {rd_addr_q == '0, rd_addr_q == last_addr, rd_real, rd_imag};

    mrd_fifo #(
        .W     ($bits(beat_t)),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (push_dat),
        .pop      (pop),
        .rd_dat   (head),
        .empty    (fifo_empty),
        .cnt      (fifo_cnt)
    );

    // Beat fields are forced to zero while nothing is buffered so idle outputs match reset values.
    assign source_valid   = ~fifo_empty;
    assign source_sop     = source_valid & head.sop;
    assign source_eop     = source_valid & head.eop;
    assign source_real    = source_valid ? head.re : '0;
    assign source_imag    = source_valid ? head.im : '0;
    assign source_dftpts  = dftpts_q;
    assign source_inverse = inverse_q;
    assign source_ongoing = (state != IDLE);
    assign rd_addr        = rd_cnt;
endmodule

// File: doc/mrd_source_stream.md
# mrd_source_stream

Source-side streamer of the mixed radix DFT core: the transmitting end of the ST_OUT streaming protocol whose receiving end is the sink. Runs when the control FSM puts the memory top in source state (state 11). On a start pulse it reads dftpts result samples from the result memory in address order and emits them as a valid/ready stream with sop/eop framing, dftpts and inverse. It reports source_ongoing back to the control FSM through the stat path.

## Interface
Parameters:
- DW, 18, width of each real/imag sample
- AW, 12, memory address width (covers dftpts up to 4095)

Ports:
- clk  in  1  sole clock; everything is rising-edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  one-cycle pulse from the control FSM on entering source state
- dftpts  in  12  number of DFT points; sampled on start
- inverse  in  1  inverse flag; sampled on start
- rd_en  out  1  memory read strobe
- rd_addr  out  AW  memory read address
- rd_real  in  DW  memory read data, real part; valid exactly 1 cycle after rd_en
- rd_imag  in  DW  memory read data, imaginary part; same timing as rd_real
- source_valid  out  1  stream beat valid
- source_ready  in  1  downstream accepts the beat
- source_sop  out  1  first beat of the frame
- source_eop  out  1  last beat of the frame
- source_real  out  DW  beat data, real part
- source_imag  out  DW  beat data, imaginary part
- source_dftpts  out  12  latched dftpts, constant over the frame
- source_inverse  out  1  latched inverse, constant over the frame
- source_ongoing  out  1  high from the cycle after start until the eop handshake
- done  out  1  one-cycle pulse in the cycle after the eop handshake

## Operation
- FSM has three states:
  - IDLE: start with dftpts≠0 latches dftpts and inverse, clears rd_cnt, and moves to RUN. start with dftpts=0 is ignored.
  - RUN: issues reads. Moves to DRAIN once the read for address dftpts-1 has been issued.
  - DRAIN: waits for the eop handshake, then goes to IDLE with done=1 for one cycle.
- start is ignored in RUN and DRAIN.
- Read issue: rd_en=1 when in RUN and (fifo_cnt + inflight − pop) < 2.
  - pop = source_valid & source_ready.
  - inflight = rd_en of the previous cycle.
  - rd_addr = rd_cnt. rd_cnt increments on each rd_en.
- Output buffer is a 2-entry FIFO of {sop, eop, real, imag}.
  - An entry is pushed in the cycle the read data returns.
  - sop is set when the address is 0. eop is set when the address is dftpts-1. If dftpts=1, one beat carries both sop and eop.
  - source_* fields are driven from the FIFO head. source_valid = FIFO non-empty.
  - Push and pop in the same cycle are both allowed.
- Handshake rule: while source_valid=1 and source_ready=0, all source_* outputs hold stable. source_valid never drops without a handshake.
- source_dftpts and source_inverse hold their latched values until the next accepted start.
- FIFO can never overflow: the credit rule guarantees fifo_cnt ≤ 2. A write into a full FIFO is a design error and the bench checks for it as an assertion.
- Reset at any time, including mid-frame:
  - FSM goes to IDLE, FIFO is emptied, any in-flight read data is discarded, rd_cnt=0.
  - No partial eop is sent afterwards.

## Timing
- Reset values: rd_en=0, rd_addr=0, source_valid=0, source_sop=0, source_eop=0, source_real=0, source_imag=0, source_dftpts=0, source_inverse=0, source_ongoing=0, done=0.
- start in cycle t:
  - rd_en=1 with addr 0 in t+1.
  - Data returns in t+2 and is pushed at the end of t+2.
  - source_valid=1 with sop in t+3.
- source_ongoing=1 from t+1 through the cycle of the eop handshake.
- With source_ready held at 1: one beat per cycle, no bubbles. The frame takes dftpts+3 cycles from start to done.
- After ready is deasserted, at most 1 further read is issued. Streaming resumes with no lost or duplicated beats.
- A new start is accepted in the cycle done is high (state is already IDLE), giving back-to-back frames.

## Test plan
- dftpts=12, memory holds real=addr, imag=−addr, ready=1 -> addresses 0..11 read, 12 beats in order, sop on beat 0, eop on beat 11, first valid at t+3, done at t+15.
- dftpts=1200 with random ready (50%) -> 1200 beats, exact order, outputs stable while stalled, FIFO never above 2, no duplicated beats.
- dftpts=1 -> single beat with sop=eop=1; dftpts=0 -> no read, source_ongoing stays 0.
- ready=0 from the first valid for 20 cycles -> exactly 2 reads issued, beat 0 held stable, then full rate once ready=1.
- start pulsed mid-frame -> ignored, frame completes unchanged; start in the done cycle -> second frame follows with no gap in reads.
- rst asserted mid-frame (beat 500 of 1200) -> all outputs at reset values next cycle; a fresh start then yields a clean frame starting at sop, address 0.
